// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and operation codes for the memory access arbiter
package mem_arb_pkg;
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;
endpackage

// File: rtl/mem_arb_grant.sv
// mem_arb_grant: two-way grant decision; round-robin with a last-grant pointer when MEM_ARB_RR_EN is defined, fixed priority (req0 first) otherwise
module mem_arb_grant (
`ifdef MEM_ARB_RR_EN
   input  logic clk,
   input  logic reset,
   input  logic i_en,
`endif
   input  logic i_req0,
   input  logic i_req1,
   output logic o_grant
);
`ifdef MEM_ARB_RR_EN
   logic r_last;
   // remember the most recent winner so a tie goes to the other side; reset favours requester 0
   always_ff @(posedge clk)
      if (reset) r_last <= 1'b1;
      else if (i_en) r_last <= o_grant;
   // a tie goes to whoever did not win last; a lone request wins outright
   always_comb o_grant = (i_req0 && i_req1) ? !r_last : i_req1;
`else
   // requester 0 always wins a tie
   always_comb o_grant = i_req1 && !i_req0;
`endif
endmodule

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: serialises two requesters onto one word-addressed array through a SETUP/ACCESS/DONE cycle; MEM_ARB_RR_EN selects round-robin tie breaking
module mem_access_arbiter
   import mem_arb_pkg::*;
#(
   parameter  int WIDTH  = 8,
   parameter  int WORDS  = 4,
   localparam int ADDR_W = $clog2(WORDS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              op0,
   input  logic              op1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [WIDTH-1:0]  wdata0,
   input  logic [WIDTH-1:0]  wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic [WIDTH-1:0]  rdata,
   output logic              busy,
   output logic [WORDS-1:0]  mem_sel,
   output logic              mem_rw,
   output logic [WIDTH-1:0]  mem_wdata,
   input  logic [WIDTH-1:0]  mem_rdata
);
   state_t              r_state, w_next;
   logic                r_op, r_id;
   logic [ADDR_W-1:0]   r_addr;
   logic [WIDTH-1:0]    r_wdata, r_rdata;
   logic                w_any, w_grant, w_busy, w_take;

   assign w_any  = req0 | req1;
   assign w_take = (r_state == IDLE) && w_any;
   assign rdata  = r_rdata;

   mem_arb_grant u_grant (
`ifdef MEM_ARB_RR_EN
      .clk     (clk),
      .reset   (reset),
      .i_en    (w_take),
`endif
      .i_req0  (req0),
      .i_req1  (req1),
      .o_grant (w_grant)
   );

   // phase register; reset from any phase returns to IDLE
   always_ff @(posedge clk) r_state <= reset ? IDLE : w_next;

   // fixed four-phase sequence; memory strobes and acks decode from the phase
   always_comb begin
      w_busy    = r_state != IDLE;
      w_next    = r_state == IDLE   ? (w_any ? SETUP : IDLE) :
                  r_state == SETUP  ? ACCESS :
                  r_state == ACCESS ? DONE : IDLE;
      mem_sel   = w_busy ? WORDS'(1) << r_addr : '0;
      mem_rw    = (r_state == ACCESS) && (r_op == OP_WRITE);
      mem_wdata = w_busy ? r_wdata : '0;
      ack0      = (r_state == DONE) && !r_id;
      ack1      = (r_state == DONE) && r_id;
      busy      = w_busy;
   end

   // latch the winner's request in IDLE; capture inverted array data at the end of a read ACCESS
   always_ff @(posedge clk) begin
      if (reset) begin
         r_op    <= OP_READ;
         r_id    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
      end else begin
         if (w_take) begin
            r_id    <= w_grant;
            r_op    <= w_grant ? op1 : op0;
            r_addr  <= w_grant ? addr1 : addr0;
            r_wdata <= w_grant ? wdata1 : wdata0;
         end
         if (r_state == ACCESS && r_op == OP_READ) r_rdata <= ~mem_rdata;
      end
   end
endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb_mem_access_arbiter: directed and randomized checks of mem_access_arbiter against a transaction-level model with an emulated active-low array
module tb_mem_access_arbiter;
   localparam int WIDTH = 8;
   localparam int WORDS = 4;
   localparam int AW    = 2;
`ifdef MEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset, req0, req1, op0, op1;
   logic [AW-1:0] addr0, addr1;
   logic [WIDTH-1:0] wdata0, wdata1, mem_rdata;
   logic ack0, ack1, busy, mem_rw;
   logic [WIDTH-1:0] rdata, mem_wdata;
   logic [WORDS-1:0] mem_sel;

   int n_tests = 0;
   int n_fail  = 0;
   bit started = 1'b0;

   logic [WIDTH-1:0] mem [WORDS];
   int               m_ph = 0;
   logic             m_id, m_op, m_last;
   logic [AW-1:0]    m_addr;
   logic [WIDTH-1:0] m_wdata, m_rdata;

   always #5 clk = ~clk;

   mem_access_arbiter #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
      .clk(clk), .reset(reset), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy), .mem_sel(mem_sel),
      .mem_rw(mem_rw), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic pick(input logic r0, input logic r1, input logic last);
      if (r0 && r1) return RR ? !last : 1'b0;
      return r1 && !r0;
   endfunction

   // transaction model: ph counts cycles since a grant (0 = idle, ack on the third)
   always @(posedge clk) begin
      if (reset) begin
         m_ph <= 0; m_rdata <= '0; m_last <= 1'b1; m_id <= 1'b0;
         m_op <= 1'b0; m_addr <= '0; m_wdata <= '0;
      end else if (m_ph == 0) begin
         if (req0 || req1) begin
            m_id    <= pick(req0, req1, m_last);
            m_last  <= pick(req0, req1, m_last);
            m_op    <= pick(req0, req1, m_last) ? op1 : op0;
            m_addr  <= pick(req0, req1, m_last) ? addr1 : addr0;
            m_wdata <= pick(req0, req1, m_last) ? wdata1 : wdata0;
            m_ph    <= 1;
         end
      end else begin
         if (m_ph == 2) begin
            if (m_op) mem[m_addr] <= m_wdata;
            else m_rdata <= ~mem_rdata;
         end
         m_ph <= (m_ph == 3) ? 0 : m_ph + 1;
      end
   end

   always @(negedge clk) if (started) begin
      logic [WORDS-1:0] es;
      es = '0;
      if (m_ph != 0) es[m_addr] = 1'b1;
      check("busy", 64'(busy), 64'(m_ph != 0));
      check("mem_sel", 64'(mem_sel), 64'(es));
      check("mem_rw", 64'(mem_rw), 64'(m_ph == 2 && m_op));
      check("mem_wdata", 64'(mem_wdata), m_ph != 0 ? 64'(m_wdata) : 64'(0));
      check("ack0", 64'(ack0), 64'(m_ph == 3 && !m_id));
      check("ack1", 64'(ack1), 64'(m_ph == 3 && m_id));
      check("rdata", 64'(rdata), 64'(m_rdata));
   end

   task automatic nxt();
      @(negedge clk);
      mem_rdata = (m_ph == 2) ? ~mem[m_addr] : WIDTH'($urandom);
   endtask

   initial begin
      foreach (mem[i]) mem[i] = WIDTH'($urandom);
      reset = 1'b1; req0 = 0; req1 = 0; op0 = 0; op1 = 0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; mem_rdata = '0;
      nxt(); nxt();
      started = 1'b1;
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_sel", 64'(mem_sel), 64'(0));
      check("rst_rdata", 64'(rdata), 64'(0));
      check("rst_ack", 64'({ack0, ack1}), 64'(0));
      reset = 1'b0;
      nxt();
      check("idle_sel", 64'(mem_sel), 64'(0));
      req0 = 1; op0 = 1; addr0 = 2; wdata0 = 8'hA5;
      nxt(); req0 = 0;
      check("w_sel1", 64'(mem_sel), 64'(4'b0100));
      check("w_rw1", 64'(mem_rw), 64'(0));
      check("w_wdata", 64'(mem_wdata), 64'(8'hA5));
      nxt();
      check("w_sel2", 64'(mem_sel), 64'(4'b0100));
      check("w_rw2", 64'(mem_rw), 64'(1));
      nxt();
      check("w_sel3", 64'(mem_sel), 64'(4'b0100));
      check("w_rw3", 64'(mem_rw), 64'(0));
      check("w_ack0", 64'(ack0), 64'(1));
      nxt();
      check("w_idle", 64'(busy), 64'(0));
      req1 = 1; op1 = 0; addr1 = 2;
      nxt(); req1 = 0;
      nxt();
      check("r_rw", 64'(mem_rw), 64'(0));
      nxt();
      check("r_ack1", 64'(ack1), 64'(1));
      check("r_rdata", 64'(rdata), 64'(8'hA5));
      nxt();
      req0 = 1; op0 = 1; addr0 = 1; wdata0 = 8'h3C;
      nxt(); req0 = 0;
      nxt();
      check("x_rw", 64'(mem_rw), 64'(1));
      reset = 1;
      nxt();
      check("x_rw0", 64'(mem_rw), 64'(0));
      check("x_sel0", 64'(mem_sel), 64'(0));
      check("x_busy0", 64'(busy), 64'(0));
      check("x_ack", 64'({ack0, ack1}), 64'(0));
      reset = 0;
      nxt();
      check("x_idle", 64'(busy), 64'(0));
      req0 = 1; op0 = 0; addr0 = 3;
      for (int i = 1; i <= 8; i++) begin
         nxt();
         if (i == 3 || i == 7) check("hold_ack0", 64'(ack0), 64'(1));
      end
      req0 = 0;
      repeat (4) nxt();
      reset = 1; req0 = 1; req1 = 1; op0 = 0; op1 = 0; addr0 = 0; addr1 = 3;
      nxt(); nxt();
      reset = 0;
      for (int i = 1; i <= 16; i++) begin
         nxt();
         if (i % 4 == 3) begin
            check("tie_ack0", 64'(ack0), 64'((i == 3 || i == 11) ? 1'b1 : !RR));
            check("tie_ack1", 64'(ack1), 64'(RR && (i == 7 || i == 15)));
         end
      end
      req0 = 0; req1 = 0;
      repeat (4) nxt();
      for (int i = 0; i < 600; i++) begin
         nxt();
         reset  = ($urandom_range(0, 59) == 0);
         req0   = ($urandom_range(0, 2) != 0);
         req1   = ($urandom_range(0, 2) != 0);
         op0    = 1'($urandom);
         op1    = 1'($urandom);
         addr0  = AW'($urandom);
         addr1  = AW'($urandom);
         wdata0 = WIDTH'($urandom);
         wdata1 = WIDTH'($urandom);
      end
      reset = 0; req0 = 0; req1 = 0;
      repeat (6) nxt();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
